// File: rtl/acl_tilt_pkg.sv
// Shared types and constants for the accelerometer tilt filter: FSM states,
// direction codes and the X/Y/Z field layout of the packed 15-bit sample word.
package acl_tilt_pkg;

    localparam int AXIS_W = 5;
    localparam int MAG_W  = 4;

    localparam int X_MSB = 14;
    localparam int X_LSB = 10;
    localparam int Y_MSB = 9;
    localparam int Y_LSB = 5;
    localparam int Z_MSB = 4;
    localparam int Z_LSB = 0;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_CALC = 2'd2
    } state_t;

endpackage

// File: rtl/acl_tilt_filter_if.sv
// Control, raw-sample and filtered-result signals of the tilt filter.
// The cal input exists only when ACL_TILT_CAL_EN is defined.
interface acl_tilt_filter_if;
    logic        enable;
    logic [14:0] acl_data;
`ifdef ACL_TILT_CAL_EN
    logic        cal;
`endif
    logic [14:0] filt_data;
    logic        filt_valid;
    logic [1:0]  x_dir;
    logic [1:0]  y_dir;
    logic [3:0]  x_mag;
    logic [3:0]  y_mag;
    logic        busy;

`ifdef ACL_TILT_CAL_EN
    modport master (output enable, acl_data, cal,
                    input  filt_data, filt_valid, x_dir, y_dir, x_mag, y_mag, busy);
    modport slave  (input  enable, acl_data, cal,
                    output filt_data, filt_valid, x_dir, y_dir, x_mag, y_mag, busy);
`else
    modport master (output enable, acl_data,
                    input  filt_data, filt_valid, x_dir, y_dir, x_mag, y_mag, busy);
    modport slave  (input  enable, acl_data,
                    output filt_data, filt_valid, x_dir, y_dir, x_mag, y_mag, busy);
`endif
endinterface

// File: rtl/acl_axis_cond.sv
// One axis of the tilt filter: window accumulator, floor average, offset
// removal with saturation, dead-zone, and direction/magnitude decode.
module acl_axis_cond
    import acl_tilt_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int DEADZONE = 1
) (
    input  logic                     iclk,
    input  logic                     reset_n,
    input  logic                     clr_i,
    input  logic                     add_i,
    input  logic signed [AXIS_W-1:0] sample_i,
    input  logic signed [AXIS_W-1:0] offset_i,
    output logic signed [AXIS_W-1:0] avg_o,
    output logic signed [AXIS_W-1:0] filt_o,
    output logic [1:0]               dir_o,
    output logic [MAG_W-1:0]         mag_o
);
    localparam int ACC_W = AXIS_W + AVG_LOG2;

    logic signed [ACC_W-1:0]    acc_q;
    logic signed [AXIS_W+1:0]   diff;
    logic signed [AXIS_W+1:0]   sat_hi;
    logic signed [AXIS_W+1:0]   sat_lo;
    logic signed [AXIS_W-1:0]   sat_v;
    logic signed [AXIS_W:0]     sat_ext;
    logic [AXIS_W:0]            abs_sat;
    logic [AXIS_W:0]            abs_filt;
    logic                       dead;

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (add_i) begin
            acc_q <= acc_q + $signed({{AVG_LOG2{sample_i[AXIS_W-1]}}, sample_i});
        end
    end

    // Arithmetic shift floors toward -inf; a window average always fits one field.
    assign avg_o  = AXIS_W'(acc_q >>> AVG_LOG2);
    assign sat_hi = $signed({3'b000, {(AXIS_W-1){1'b1}}});
    assign sat_lo = $signed({3'b111, {(AXIS_W-1){1'b0}}});

    always_comb begin
        diff    = (AXIS_W+2)'(avg_o) - (AXIS_W+2)'(offset_i);
        sat_v   = diff[AXIS_W-1:0];
        if (diff > sat_hi) begin
            sat_v = {1'b0, {(AXIS_W-1){1'b1}}};
        end else if (diff < sat_lo) begin
            sat_v = {1'b1, {(AXIS_W-1){1'b0}}};
        end
        sat_ext  = {sat_v[AXIS_W-1], sat_v};
        abs_sat  = sat_v[AXIS_W-1] ? $unsigned(-sat_ext) : $unsigned(sat_ext);
        dead     = (abs_sat <= (AXIS_W+1)'(DEADZONE));
        filt_o   = dead ? '0 : sat_v;
        abs_filt = dead ? '0 : abs_sat;
        mag_o    = (abs_filt > (AXIS_W+1)'(15)) ? 4'd15 : abs_filt[MAG_W-1:0];
        dir_o    = DIR_NONE;
        if (!dead) begin
            dir_o = sat_v[AXIS_W-1] ? DIR_NEG : DIR_POS;
        end
    end

endmodule

// File: rtl/acl_tilt_filter.sv
// Accelerometer tilt filter top: sample tick divider, window FSM and result
// registers around three axis conditioners. ACL_TILT_CAL_EN adds offset calibration.
module acl_tilt_filter
    import acl_tilt_pkg::*;
#(
    parameter int SAMPLE_DIV = 40000,
    parameter int AVG_LOG2   = 2,
    parameter int DEADZONE   = 1
) (
    input  logic         iclk,
    input  logic         reset_n,
    acl_tilt_filter_if.slave bus
);
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [AVG_LOG2-1:0] LAST_SAMPLE = '1;

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_cnt_q;
    logic [AVG_LOG2-1:0]   count_q;
    logic                  tick;
    logic                  acc_add;
    logic                  acc_clr;

    logic [AXIS_W-1:0]     off_eff  [3];
    logic [AXIS_W-1:0]     avg_w    [3];
    logic [AXIS_W-1:0]     filt_w   [3];
    logic [1:0]            dir_w    [3];
    logic [MAG_W-1:0]      mag_w    [3];

    logic [14:0]           filt_q;
    logic [1:0]            x_dir_q, y_dir_q;
    logic [MAG_W-1:0]      x_mag_q, y_mag_q;
    logic                  valid_q;

    assign tick = bus.enable && (tick_cnt_q == TW'(SAMPLE_DIV - 1));

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else if (!bus.enable || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.enable) state_d = S_ACC;
            S_ACC:   begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (tick && count_q == LAST_SAMPLE) begin
                    state_d = S_CALC;
                end
            end
            S_CALC:  state_d = bus.enable ? S_ACC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Dropping enable abandons the partial window outright.
    assign acc_add = (state_q == S_ACC) && tick;
    assign acc_clr = !bus.enable || (state_q == S_CALC);

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (acc_clr) begin
            count_q <= '0;
        end else if (acc_add) begin
            count_q <= count_q + 1'b1;
        end
    end

`ifdef ACL_TILT_CAL_EN
    logic              cal_pend_q;
    logic              cal_now;
    logic [AXIS_W-1:0] off_q [3];

    assign cal_now = cal_pend_q | bus.cal;

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            cal_pend_q <= 1'b0;
            for (int i = 0; i < 3; i++) off_q[i] <= '0;
        end else if (state_q == S_CALC) begin
            cal_pend_q <= 1'b0;
            if (cal_now) begin
                for (int i = 0; i < 3; i++) off_q[i] <= avg_w[i];
            end
        end else if (bus.cal) begin
            cal_pend_q <= 1'b1;
        end
    end

    // A calibrating window is judged against its own average, so it reads zero.
    for (genvar gi = 0; gi < 3; gi++) begin : g_off
        assign off_eff[gi] = ((state_q == S_CALC) && cal_now) ? avg_w[gi] : off_q[gi];
    end
`else
    logic avg_unused;
    assign avg_unused = ^{avg_w[0], avg_w[1], avg_w[2]};
    for (genvar gi = 0; gi < 3; gi++) begin : g_off
        assign off_eff[gi] = '0;
    end
`endif

    // Index 0 is Z (bits 4:0), 1 is Y, 2 is X.
    for (genvar gi = 0; gi < 3; gi++) begin : g_axis
        acl_axis_cond #(
            .AVG_LOG2 (AVG_LOG2),
            .DEADZONE (DEADZONE)
        ) u_cond (
            .iclk     (iclk),
            .reset_n  (reset_n),
            .clr_i    (acc_clr),
            .add_i    (acc_add),
            .sample_i (bus.acl_data[gi*AXIS_W +: AXIS_W]),
            .offset_i (off_eff[gi]),
            .avg_o    (avg_w[gi]),
            .filt_o   (filt_w[gi]),
            .dir_o    (dir_w[gi]),
            .mag_o    (mag_w[gi])
        );
    end

    logic z_unused;
    assign z_unused = ^{dir_w[0], mag_w[0]};

    always_ff @(posedge iclk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q  <= '0;
            x_dir_q <= DIR_NONE;
            y_dir_q <= DIR_NONE;
            x_mag_q <= '0;
            y_mag_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_q == S_CALC);
            if (state_q == S_CALC) begin
                filt_q[X_MSB:X_LSB] <= filt_w[2];
                filt_q[Y_MSB:Y_LSB] <= filt_w[1];
                filt_q[Z_MSB:Z_LSB] <= filt_w[0];
                x_dir_q             <= dir_w[2];
                y_dir_q             <= dir_w[1];
                x_mag_q             <= mag_w[2];
                y_mag_q             <= mag_w[1];
            end
        end
    end

    assign bus.filt_data  = filt_q;
    assign bus.filt_valid = valid_q;
    assign bus.x_dir      = x_dir_q;
    assign bus.y_dir      = y_dir_q;
    assign bus.x_mag      = x_mag_q;
    assign bus.y_mag      = y_mag_q;
    assign bus.busy       = ((state_q == S_ACC) && (count_q != '0)) || (state_q == S_CALC);

endmodule

// File: tb/tb_acl_tilt_filter.sv
// Self-checking bench for acl_tilt_filter: window-level reference model with a
// per-cycle compare, directed test-plan windows, then randomized traffic.
module tb_acl_tilt_filter;

    localparam int SD = 4;
    localparam int AL = 2;
    localparam int DZ = 1;
    localparam int N  = 1 << AL;

    logic iclk    = 1'b0;
    logic reset_n = 1'b0;

    acl_tilt_filter_if bus();

    acl_tilt_filter #(
        .SAMPLE_DIV (SD),
        .AVG_LOG2   (AL),
        .DEADZONE   (DZ)
    ) dut (
        .iclk    (iclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial forever #5 iclk = ~iclk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sx5(input logic [4:0] v);
        return v[4] ? int'(v) - 32 : int'(v);
    endfunction

    function automatic int fdiv(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int cond_val(input int avg, input int off);
        int v;
        v = avg - off;
        if (v > 15)  v = 15;
        if (v < -16) v = -16;
        if (abs_i(v) <= DZ) v = 0;
        return v;
    endfunction

    function automatic logic [1:0] dir_of(input int v);
        if (v > 0) return 2'b01;
        if (v < 0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [3:0] mag_of(input int v);
        int a;
        a = abs_i(v);
        return (a > 15) ? 4'd15 : a[3:0];
    endfunction

    int   run = 0, wcnt = 0;
    int   sx = 0, sy = 0, sz = 0, cx = 0, cy = 0, cz = 0;
    int   off_x = 0, off_y = 0, off_z = 0;
    bit   calc_next = 0, cal_pend = 0;
    logic [14:0] e_filt = '0;
    logic [1:0]  e_xd = '0, e_yd = '0;
    logic [3:0]  e_xm = '0, e_ym = '0;
    logic        e_valid = 1'b0, e_busy = 1'b0;

    initial begin : model
        int ax, ay, az, fx, fy, fz;
        bit cal_in, cal_now;
        forever begin
            @(posedge iclk or negedge reset_n);
            if (!reset_n) begin
                run = 0; wcnt = 0; sx = 0; sy = 0; sz = 0;
                off_x = 0; off_y = 0; off_z = 0;
                calc_next = 0; cal_pend = 0;
                e_filt = '0; e_xd = '0; e_yd = '0; e_xm = '0; e_ym = '0;
                e_valid = 1'b0; e_busy = 1'b0;
            end else begin
                cal_in = 1'b0;
`ifdef ACL_TILT_CAL_EN
                cal_in = bus.cal;
`endif
                cal_now = cal_pend || cal_in;
                e_valid = 1'b0;
                if (calc_next) begin
                    ax = fdiv(cx); ay = fdiv(cy); az = fdiv(cz);
                    if (cal_now) begin
                        off_x = ax; off_y = ay; off_z = az;
                    end
                    cal_pend = 1'b0;
                    fx = cond_val(ax, off_x);
                    fy = cond_val(ay, off_y);
                    fz = cond_val(az, off_z);
                    e_filt = {fx[4:0], fy[4:0], fz[4:0]};
                    e_xd = dir_of(fx); e_xm = mag_of(fx);
                    e_yd = dir_of(fy); e_ym = mag_of(fy);
                    e_valid = 1'b1;
                    calc_next = 0;
                end else begin
                    cal_pend = cal_now;
                end
                if (bus.enable) begin
                    run++;
                    if (run % SD == 0) begin
                        sx += sx5(bus.acl_data[14:10]);
                        sy += sx5(bus.acl_data[9:5]);
                        sz += sx5(bus.acl_data[4:0]);
                        wcnt++;
                        if (wcnt == N) begin
                            cx = sx; cy = sy; cz = sz;
                            sx = 0; sy = 0; sz = 0; wcnt = 0;
                            calc_next = 1;
                        end
                    end
                end else begin
                    run = 0; wcnt = 0; sx = 0; sy = 0; sz = 0;
                end
                e_busy = (wcnt != 0) || calc_next;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge iclk);
            chk("filt_data",  bus.filt_data,  e_filt);
            chk("filt_valid", bus.filt_valid, e_valid);
            chk("busy",       bus.busy,       e_busy);
            chk("x_dir",      bus.x_dir,      e_xd);
            chk("y_dir",      bus.y_dir,      e_yd);
            chk("x_mag",      bus.x_mag,      e_xm);
            chk("y_mag",      bus.y_mag,      e_ym);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_xyz(input int x, input int y, input int z);
        bus.acl_data = {x[4:0], y[4:0], z[4:0]};
    endtask

    task automatic next_valid(output int k);
        k = 0;
        do begin
            @(negedge iclk);
            k++;
        end while (!bus.filt_valid && k < 60);
        if (!bus.filt_valid) begin
            n_assert++;
            n_fail++;
            $display("FAIL next_valid: no filt_valid within %0d cycles", k);
        end
    endtask

    task automatic run_window(input int x0, input int x1, input int x2, input int x3,
                              input int y, input int z);
        set_xyz(x0, y, z); repeat (4) @(negedge iclk);
        set_xyz(x1, y, z); repeat (4) @(negedge iclk);
        set_xyz(x2, y, z); repeat (4) @(negedge iclk);
        set_xyz(x3, y, z); repeat (4) @(negedge iclk);
        chk("window_valid", bus.filt_valid, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        bus.enable   = 1'b0;
        bus.acl_data = '0;
`ifdef ACL_TILT_CAL_EN
        bus.cal      = 1'b0;
`endif
        chk("model_avg6",    cond_val(fdiv(24), 0), 6);
        chk("model_dz",      cond_val(fdiv(5), 0), 0);
        chk("model_neg16",   cond_val(fdiv(-64), 0), -16);
        chk("model_floor",   cond_val(fdiv(-11), 0), -3);
        chk("model_offset",  cond_val(fdiv(36), 4), 5);
        chk("model_mag_sat", mag_of(-16), 15);

        repeat (3) @(negedge iclk);
        chk("rst_filt",  bus.filt_data, 0);
        chk("rst_valid", bus.filt_valid, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_xdir",  bus.x_dir, 0);
        #2 reset_n = 1'b1;
        @(negedge iclk);

        set_xyz(6, -6, 0);
        bus.enable = 1'b1;
        next_valid(k);
        chk("first_latency", k, 17);
        chk("xy6_filt", bus.filt_data, 15'b00110_11010_00000);
        chk("xy6_xdir", bus.x_dir, 2'b01);
        chk("xy6_xmag", bus.x_mag, 6);
        chk("xy6_ydir", bus.y_dir, 2'b10);
        chk("xy6_ymag", bus.y_mag, 6);
        next_valid(k);
        chk("valid_period", k, 16);

        run_window(1, 2, 1, 1, -6, 0);
        chk("dz_xfield", bus.filt_data[14:10], 0);
        chk("dz_xdir",   bus.x_dir, 0);
        chk("dz_xmag",   bus.x_mag, 0);

        run_window(-16, -16, -16, -16, -6, 0);
        chk("neg16_xfield", bus.filt_data[14:10], 5'b10000);
        chk("neg16_xdir",   bus.x_dir, 2'b10);
        chk("neg16_xmag",   bus.x_mag, 15);

        run_window(-3, -3, -3, -2, -6, 0);
        chk("floor_xfield", bus.filt_data[14:10], 5'b11101);
        chk("floor_xmag",   bus.x_mag, 3);

        // enable dropped after two ticks of a window, then re-raised
        set_xyz(-5, 3, 2);
        repeat (7) @(negedge iclk);
        bus.enable = 1'b0;
        repeat (3) @(negedge iclk);
        chk("abort_hold", bus.filt_data[14:10], 5'b11101);
        bus.enable = 1'b1;
        set_xyz(7, 0, 0);
        next_valid(k);
        chk("reenable_latency", k, 17);
        chk("reenable_filt", bus.filt_data, {5'd7, 5'd0, 5'd0});

        // asynchronous reset between edges, mid-window
        repeat (6) @(negedge iclk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_filt", bus.filt_data, 0);
        chk("async_rst_xmag", bus.x_mag, 0);
        chk("async_rst_busy", bus.busy, 0);
        repeat (2) @(negedge iclk);
        #2 reset_n = 1'b1;
        next_valid(k);
        chk("post_rst_latency", k, 17);

`ifdef ACL_TILT_CAL_EN
        set_xyz(4, 0, 0);
        bus.cal = 1'b1;
        @(negedge iclk);
        bus.cal = 1'b0;
        repeat (15) @(negedge iclk);
        chk("cal_valid", bus.filt_valid, 1);
        chk("cal_xfield", bus.filt_data[14:10], 0);
        chk("cal_xdir", bus.x_dir, 0);
        chk("cal_xmag", bus.x_mag, 0);
        run_window(9, 9, 9, 9, 0, 0);
        chk("cal_next_x", bus.filt_data[14:10], 5'd5);
        chk("cal_next_xdir", bus.x_dir, 2'b01);
        chk("cal_next_xmag", bus.x_mag, 5);
`endif

        for (int c = 0; c < 900; c++) begin
            @(negedge iclk);
            case ($urandom_range(0, 5))
                0:       bus.acl_data = 15'h4210;
                1:       bus.acl_data = 15'h3DEF;
                default: bus.acl_data = 15'($urandom_range(0, 32767));
            endcase
            if (bus.enable && $urandom_range(0, 79) == 0) begin
                bus.enable = 1'b0;
            end else if (!bus.enable && $urandom_range(0, 2) == 0) begin
                bus.enable = 1'b1;
            end
`ifdef ACL_TILT_CAL_EN
            bus.cal = ($urandom_range(0, 39) == 0);
`endif
        end

        bus.enable = 1'b0;
        repeat (4) @(negedge iclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/acl_tilt_filter.md
Name: acl_tilt_filter

Overview:
- Sits between the SPI accelerometer reader and the VGA game logic.
- Periodically samples the packed 15-bit accelerometer word (X[14:10], Y[9:5], Z[4:0], each 5-bit two's complement) and box-averages 2^AVG_LOG2 samples per axis.
- Applies a dead-zone, then emits a filtered packed word plus per-axis direction/magnitude for sprite movement.
- Produces a one-cycle valid strobe per completed averaging window.

Parameters:
- SAMPLE_DIV, 40000, iclk cycles between sample ticks (100 Hz at 4 MHz); legal range 2..2^20.
- AVG_LOG2, 2, log2 of samples per window (1..4).
- DEADZONE, 1, averages with |avg| <= DEADZONE are forced to 0 (0..15).

Ports:
- iclk  in  1  system clock (4 MHz accelerometer domain)
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run filter; low = idle/clear window
- acl_data  in  15  raw packed X/Y/Z samples
- filt_data  out  15  filtered packed X/Y/Z, same packing/sign format
- filt_valid  out  1  one-cycle pulse when filt_data/dir/mag update
- x_dir  out  2  00 none, 01 positive, 10 negative (11 never)
- y_dir  out  2  as x_dir
- x_mag  out  4  |filtered X|, saturated at 15
- y_mag  out  4  |filtered Y|, saturated at 15
- busy  out  1  high while a window is partially accumulated

Behaviour:
- Reset (async, reset_n=0): all outputs 0, tick counter 0, sample count 0, accumulators 0, state S_IDLE, offsets 0.
- Tick counter counts 0..SAMPLE_DIV-1 while enable=1; tick is asserted in the cycle the count equals SAMPLE_DIV-1, then the counter wraps to 0.
- FSM S_IDLE:
  - enable=1 -> S_ACC.
- FSM S_ACC:
  - On tick, add sign-extended axis samples to three accumulators. Each accumulator is (5+AVG_LOG2)-bit signed, so overflow is impossible.
  - Increment the sample count on each tick.
  - On the tick where count == 2^AVG_LOG2-1, go to S_CALC.
- FSM S_CALC (exactly 1 cycle):
  - avg = acc >>> AVG_LOG2 (arithmetic shift, rounds toward -inf).
  - Subtract the per-axis offset; saturate the result to [-16,15].
  - Apply the dead-zone.
  - Register filt_data, x_dir, y_dir, x_mag, y_mag.
  - Clear accumulators and count; go to S_ACC (S_IDLE if enable=0).
- filt_valid is high in the cycle after S_CALC, for exactly one cycle. Latency from the final-sample tick cycle to filt_valid is 2 cycles.
- Magnitude: -16 maps to mag 15 (saturate). Z axis is filtered and dead-zoned only; it has no dir/mag outputs.
- busy = (state==S_ACC && count!=0) || state==S_CALC.
- enable falls mid-window: at the next edge, discard the partial window, clear accumulators, count and tick counter, go to S_IDLE. Outputs hold their last values and no filt_valid is produced.
- enable rises: the first tick occurs SAMPLE_DIV cycles later.
- acl_data is sampled only on tick cycles; changes between ticks are ignored.
- reset_n asserted mid-window: immediate clear, no partial output.

Optional Feature:
- Macro: ACL_TILT_CAL_EN.
- Defined:
  - Adds input port cal (1 bit). A cal pulse sets a pending flag, which is held until the next S_CALC.
  - In that S_CALC, the per-axis offsets load the raw (pre-offset) averages. The window's outputs are computed with the new offsets (so they read 0, dir 00, mag 0), and filt_valid still pulses.
  - If cal coincides with the S_CALC cycle, it applies to that window.
  - Offsets are cleared only by reset.
- Undefined: no cal port, offsets are constant 0, and no offset registers are built.

Decomposition:
- Package acl_tilt_pkg holds:
  - FSM state encoding (S_IDLE, S_ACC, S_CALC);
  - DIR_NONE/DIR_POS/DIR_NEG constants;
  - axis field bit positions (X_MSB/LSB etc.);
  - AXIS_W=5.
- One sub-module, acl_axis_cond, instantiated three times: accumulate, shift, offset-subtract/saturate, dead-zone, dir/mag. The top module holds the tick counter, FSM and output registers.

Test Plan:
- SAMPLE_DIV=4, AVG_LOG2=2, DEADZONE=1, constant acl_data X=+6,Y=-6,Z=0 -> filt_valid every 16 cycles:
  - filt_data X=6, Y=-6 (11010);
  - x_dir=01, x_mag=6; y_dir=10, y_mag=6.
- X samples 1,2,1,1 (sum 5, avg 1) -> within dead-zone: X field 0, x_dir=00, x_mag=0.
- X samples -16 x4 -> X field 10000, x_dir=10, x_mag=15 (saturated). X samples -3,-3,-3,-2 -> avg -3 (shift rounds down).
- enable dropped after 2 ticks, re-raised -> no filt_valid for the aborted window; the next window averages only post-re-enable samples and outputs hold the prior values meanwhile.
- reset_n pulsed low mid-window (asynchronous, between edges) -> all outputs 0 immediately; the first filt_valid comes a full window after release.
- ACL_TILT_CAL_EN: hold X=+4, pulse cal -> that window outputs X=0; the next window with X=+9 outputs X=5, x_dir=01, x_mag=5.
